mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYC, default 5, cycles from accepted mult/multu until HI/LO hold the result.
REQ-002 Parameter DIV_CYC, default 10, cycles from accepted div/divu until HI/LO hold the result.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 A  input  32  E-stage forwarded rs value.
REQ-006 B  input  32  E-stage forwarded rt value.
REQ-007 MDUOp  input  4  operation code for the E-stage instruction: NONE, MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
REQ-008 Start  input  1  one-cycle pulse, high while a mult/multu/div/divu sits in E.
REQ-009 Req  input  1  exception/interrupt request; cancels side effects of the E-stage instruction this cycle.
REQ-010 Busy  output  1  unit occupied; consumed by the stall unit as E_Busy.
REQ-011 HI  output  32  architectural HI register.
REQ-012 LO  output  32  architectural LO register.
REQ-013 MDUOut  output  32  read data for mfhi/mflo, fed to the E-stage result mux.

Function
REQ-014 Start is accepted when Start=1, Req=0, and cnt=0; otherwise it is ignored.
REQ-015 On acceptance: compute the result into hidden hi_tmp/lo_tmp; load cnt with MULT_CYC for multiplies or DIV_CYC for divides.
REQ-016 MULT: {hi_tmp,lo_tmp} = signed(A) * signed(B), full 64 bits; MULTU: the same, unsigned.
REQ-017 DIV: lo_tmp = signed quotient truncated toward zero; hi_tmp = remainder with the sign of the dividend. DIVU: unsigned quotient and remainder.
REQ-018 Divide with B=0: the count still runs DIV_CYC cycles; HI and LO remain unchanged at the end.
REQ-019 While cnt>0, cnt decrements by 1 each cycle; on the edge where cnt goes 1->0, HI<=hi_tmp and LO<=lo_tmp.
REQ-020 Busy = (Start & ~Req) | (cnt != 0), combinational; it is high in the Start cycle plus the next MULT_CYC/DIV_CYC cycles.
REQ-021 MTHI/MTLO with Req=0 and cnt=0 write A to HI/LO at the next edge; they are suppressed when Req=1.
REQ-022 MDUOut = HI for MFHI, LO for MFLO, else 32'd0; combinational read of the current registers.
REQ-023 Operations issued while cnt>0 (an upstream stall violation) are ignored: no restart, no HI/LO write, and the in-flight result is preserved.
REQ-024 Req=1 never aborts an operation already in flight; the count completes and HI/LO update normally.

Reset
REQ-025 Reset asserted at any time, including mid-operation: HI=0, LO=0, hi_tmp=0, lo_tmp=0, cnt=0, Busy=0 (when Start=0), asynchronously; the pending result is discarded.

Structure
REQ-026 MDUOp encodings (MDU_NONE..MDU_MTLO) belong in the shared const.v alongside the GRFA3_* constants; the decoder drives MDUOp and Start.
REQ-027 Single module, no sub-module; cnt is 4 bits, sized for DIV_CYC<=15.

Verification
REQ-028 Reset, then MULT with A=-3, B=5 and Start at cycle 0 -> Busy=1 for cycles 0-5 and 0 at cycle 6; at cycle 6 HI=32'hFFFFFFFF, LO=32'hFFFFFFF1; MFHI at cycle 6 -> MDUOut=32'hFFFFFFFF.
REQ-029 DIVU with A=7, B=2 at cycle 0 -> Busy=1 for cycles 0-10; at cycle 11 LO=3, HI=1. DIV with A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF.
REQ-030 DIV with A=5, B=0 after MTHI 0x11 and MTLO 0x22 -> Busy runs 10 cycles; HI=0x11 and LO=0x22 afterwards.
REQ-031 Start with Req=1 -> Busy=0, cnt stays 0, HI/LO unchanged; MTLO with Req=1 -> LO unchanged.
REQ-032 MULT started, then reset asserted at cycle 3 -> HI=LO=0 and Busy=0 immediately, with no later update; a second Start injected at cycle 2 of a multiply is ignored, and the first result lands at cycle 6.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   mdu_op_e   - MDUOp encodings driven by the decoder
//   CNT_W      - width of the completion counter (latencies up to 15)
//   is_mul     - true for mult/multu
//   is_muldiv  - true for the four long-latency operations
package mdu_pkg;

   localparam int CNT_W = 4;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   function automatic logic is_mul(mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU);
   endfunction

   function automatic logic is_muldiv(mdu_op_e op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit with architectural HI/LO registers.
//
// Ports
//   clk     in   clock, all state on rising edge
//   reset   in   asynchronous active-high reset
//   A, B    in   forwarded rs / rt values (32 bits)
//   MDUOp   in   operation code (mdu_op_e)
//   Start   in   pulse while a mult/multu/div/divu sits in E
//   Req     in   exception/interrupt request, cancels E-stage side effects
//   Busy    out  unit occupied (to the stall unit)
//   HI, LO  out  architectural HI/LO
//   MDUOut  out  mfhi/mflo read data, 0 for other operations
//
// Handshake: Start is accepted only when Start=1, Req=0 and the counter is
// idle, for a mult/div class MDUOp. The result is computed at acceptance
// into hidden hi_tmp/lo_tmp and published to HI/LO on the edge where the
// counter steps from 1 to 0. Anything issued while the counter runs is
// ignored; Req never aborts an operation already in flight.
module mdu
   import mdu_pkg::*;
#(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [3:0]  MDUOp,
   input  logic        Start,
   input  logic        Req,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYC);
   localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYC);

   mdu_op_e          op;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      hi_tmp;
   logic [31:0]      lo_tmp;
   logic             idle;
   logic             accept;
   logic [31:0]      res_hi;
   logic [31:0]      res_lo;
   logic [63:0]      prod_s;
   logic [63:0]      prod_u;
   logic signed [63:0] a_sx;
   logic signed [63:0] b_sx;

   assign op     = mdu_op_e'(MDUOp);
   assign idle   = (cnt == '0);
   assign accept = Start && !Req && idle && is_muldiv(op);
   assign Busy   = (Start && !Req) || !idle;

   assign a_sx   = {{32{A[31]}}, A};
   assign b_sx   = {{32{B[31]}}, B};
   assign prod_s = 64'(a_sx * b_sx);
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Result staged at acceptance. A divide by zero re-stages the current
   // HI/LO so the completion write leaves them unchanged; this is safe
   // because nothing else can write HI/LO while the counter runs.
   always_comb begin
      res_hi = HI;
      res_lo = LO;
      case (op)
         MDU_MULT:  {res_hi, res_lo} = prod_s;
         MDU_MULTU: {res_hi, res_lo} = prod_u;
         MDU_DIV: begin
            if (B != 32'd0) begin
               res_lo = 32'($signed(A) / $signed(B));
               res_hi = 32'($signed(A) % $signed(B));
            end
         end
         MDU_DIVU: begin
            if (B != 32'd0) begin
               res_lo = A / B;
               res_hi = A % B;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         hi_tmp <= 32'd0;
         lo_tmp <= 32'd0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else if (!idle) begin
         cnt <= cnt - 1'b1;
         if (cnt == CNT_W'(1)) begin
            HI <= hi_tmp;
            LO <= lo_tmp;
         end
      end else if (accept) begin
         hi_tmp <= res_hi;
         lo_tmp <= res_lo;
         cnt    <= is_mul(op) ? MULT_CNT : DIV_CNT;
      end else if (!Req) begin
         if (op == MDU_MTHI) HI <= A;
         if (op == MDU_MTLO) LO <= A;
      end
   end

   always_comb begin
      MDUOut = 32'd0;
      case (op)
         MDU_MFHI: MDUOut = HI;
         MDU_MFLO: MDUOut = LO;
         default:  MDUOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed-vector bench for mdu with hand-computed expectations.
// Inputs change 1 time unit after a rising edge and outputs are sampled
// 2 units after that, away from the active edge.
module tb_mdu;
   import mdu_pkg::*;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic        clk;
   logic        reset;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Req;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   int n_checks = 0;
   int n_errors = 0;

   mdu #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk    (clk),
      .reset  (reset),
      .A      (A),
      .B      (B),
      .MDUOp  (MDUOp),
      .Start  (Start),
      .Req    (Req),
      .Busy   (Busy),
      .HI     (HI),
      .LO     (LO),
      .MDUOut (MDUOut)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // checking task
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      MDUOp = MDU_NONE;
      Start = 1'b0;
      Req   = 1'b0;
      A     = 32'd0;
      B     = 32'd0;
   endtask

   // Issue a long op at cycle 0, check Busy over cycles 0..cyc and low at
   // cycle cyc+1, then check HI/LO there. Leaves time at cycle cyc+1.
   task automatic run_op(input string tag, input mdu_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input int cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      MDUOp = op; A = a; B = b; Start = 1'b1;
      #1 check({tag, " busy c0"}, 32'(Busy), 32'd1);
      tick();
      idle_inputs();
      for (int i = 1; i <= cyc; i++) begin
         #1 check($sformatf("%s busy c%0d", tag, i), 32'(Busy), 32'd1);
         tick();
      end
      #1 check($sformatf("%s busy c%0d", tag, cyc + 1), 32'(Busy), 32'd0);
      check({tag, " hi"}, HI, exp_hi);
      check({tag, " lo"}, LO, exp_lo);
   endtask

   task automatic move_to(input mdu_op_e op, input logic [31:0] a);
      MDUOp = op; A = a;
      tick();
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      check("reset hi", HI, 32'd0);
      check("reset lo", LO, 32'd0);
      check("reset busy", 32'(Busy), 32'd0);
      check("reset mdout", MDUOut, 32'd0);
      tick();

      // multiplies
      run_op("mult -3*5", MDU_MULT, 32'hFFFF_FFFD, 32'd5, MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      MDUOp = MDU_MFHI;
      #1 check("mfhi", MDUOut, 32'hFFFF_FFFF);
      MDUOp = MDU_MFLO;
      #1 check("mflo", MDUOut, 32'hFFFF_FFF1);
      tick(); idle_inputs();
      run_op("multu ff*2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, MULT_CYC, 32'h0000_0001, 32'hFFFF_FFFE);
      run_op("mult ff*2", MDU_MULT, 32'hFFFF_FFFF, 32'd2, MULT_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      // divides
      run_op("divu 7/2", MDU_DIVU, 32'd7, 32'd2, DIV_CYC, 32'd1, 32'd3);
      run_op("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, DIV_CYC, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 7/-2", MDU_DIV, 32'd7, 32'hFFFF_FFFE, DIV_CYC, 32'd1, 32'hFFFF_FFFD);
      run_op("divu big", MDU_DIVU, 32'hFFFF_FFF9, 32'd2, DIV_CYC, 32'd1, 32'h7FFF_FFFC);

      // moves and divide by zero
      move_to(MDU_MTHI, 32'h11);
      move_to(MDU_MTLO, 32'h22);
      #1 check("mthi", HI, 32'h11);
      check("mtlo", LO, 32'h22);
      run_op("div by 0", MDU_DIV, 32'd5, 32'd0, DIV_CYC, 32'h11, 32'h22);

      // Req cancels the E-stage instruction
      MDUOp = MDU_MULT; A = 32'd9; B = 32'd9; Start = 1'b1; Req = 1'b1;
      #1 check("req start busy", 32'(Busy), 32'd0);
      tick(); idle_inputs();
      #1 check("req start busy next", 32'(Busy), 32'd0);
      repeat (MULT_CYC + 1) tick();
      #1 check("req start hi", HI, 32'h11);
      check("req start lo", LO, 32'h22);
      MDUOp = MDU_MTLO; A = 32'h99; Req = 1'b1;
      tick(); idle_inputs();
      #1 check("req mtlo", LO, 32'h22);

      // second Start and an MTHI during a multiply are ignored
      MDUOp = MDU_MULT; A = 32'd3; B = 32'd4; Start = 1'b1;
      tick(); idle_inputs();                          // cycle 1
      tick();                                         // cycle 2
      MDUOp = MDU_DIV; A = 32'd100; B = 32'd7; Start = 1'b1;
      tick(); idle_inputs();                          // cycle 3
      MDUOp = MDU_MTHI; A = 32'h55;
      tick(); idle_inputs();                          // cycle 4
      tick();                                         // cycle 5
      #1 check("inflight busy c5", 32'(Busy), 32'd1);
      check("inflight hi c5", HI, 32'h11);
      tick();                                         // cycle 6
      #1 check("inflight busy c6", 32'(Busy), 32'd0);
      check("inflight hi", HI, 32'd0);
      check("inflight lo", LO, 32'd12);

      // Req during flight does not abort
      MDUOp = MDU_MULT; A = 32'd6; B = 32'd7; Start = 1'b1;
      tick(); idle_inputs();
      tick();
      Req = 1'b1;
      tick(); Req = 1'b0;
      repeat (MULT_CYC - 2) tick();
      #1 check("req inflight busy", 32'(Busy), 32'd0);
      check("req inflight lo", LO, 32'd42);

      // reset mid-operation
      MDUOp = MDU_MULT; A = 32'd2; B = 32'd3; Start = 1'b1;
      tick(); idle_inputs();
      tick(); tick();                                 // cycle 3
      reset = 1'b1;
      #1 check("rst mid hi", HI, 32'd0);
      check("rst mid lo", LO, 32'd0);
      check("rst mid busy", 32'(Busy), 32'd0);
      tick();
      reset = 1'b0;
      repeat (MULT_CYC + 2) tick();
      #1 check("rst after hi", HI, 32'd0);
      check("rst after lo", LO, 32'd0);
      check("rst after busy", 32'(Busy), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
